// File: rtl/mulcnt_pkg.sv
// Shared definitions for gpio_mulcnt: FSM states, register addresses and status bit positions.
package mulcnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_READY_BIT = 1;

endpackage

// File: rtl/mulcnt_popcount.sv
// Combinational population count over a W-bit word.
module mulcnt_popcount #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/gpio_mulcnt.sv
// Register-mapped shift-add multiplier with result popcount and operation counter.
// Optional build macro MULCNT_POPCNT_EN enables the COUNT state and the L register.
module gpio_mulcnt
  import mulcnt_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int RES_W = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int PW    = 2 * OP_W;
  localparam int EXT_W = (PW > RES_W) ? PW : RES_W;
  localparam int POP_W = $clog2(RES_W + 1);
  localparam int MC_W  = $clog2(OP_W + 1);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic [PW-1:0]     mcand_q;
  logic [OP_W-1:0]   mplier_q;
  logic [PW-1:0]     product_q;
  logic [MC_W-1:0]   step_q;
  logic [RES_W-1:0]  w_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       gpio_in_s;
  logic [31:0]       rd_data;
  logic [EXT_W-1:0]  prod_ext;
  logic [POP_W-1:0]  l_val;
  logic              fits;
  logic              ready;
  logic              start;
  logic              wr_a1, wr_a2;
  logic              unused_wdata;

  assign start  = swr && (saddress == ADDR_CTRL);
  assign wr_a1  = swr && (saddress == ADDR_A1);
  assign wr_a2  = swr && (saddress == ADDR_A2);
  assign ready  = (state_q == ST_IDLE);

  // Product bits above RES_W decide whether the readable result is complete.
  assign prod_ext = EXT_W'(product_q);
  assign fits     = ((prod_ext >> RES_W) == '0);

  assign unused_wdata = ^(sdata_in >> OP_W);

`ifdef MULCNT_POPCNT_EN
  localparam state_t MULT_EXIT = ST_COUNT;

  logic [POP_W-1:0] pop_cnt;
  logic [POP_W-1:0] pop_q;
  logic [POP_W-1:0] l_q;

  mulcnt_popcount #(
    .W  (RES_W),
    .CW (POP_W)
  ) u_popcount (
    .din (prod_ext[RES_W-1:0]),
    .cnt (pop_cnt)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pop_q <= '0;
      l_q   <= '0;
    end else begin
      if (state_q == ST_COUNT) pop_q <= pop_cnt;
      if (state_q == ST_DONE)  l_q   <= pop_q;
    end
  end

  assign l_val = l_q;
`else
  localparam state_t MULT_EXIT = ST_DONE;

  assign l_val = '0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_MULT;
      ST_MULT:  if (step_q == MC_W'(OP_W - 1)) state_d = MULT_EXIT;
      ST_COUNT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand registers take writes at any time; the running operation uses its own copies.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      if (wr_a1) a1_q <= sdata_in[OP_W-1:0];
      if (wr_a2) a2_q <= sdata_in[OP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      step_q    <= '0;
      w_q       <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q   <= PW'(a1_q);
            mplier_q  <= a2_q;
            product_q <= '0;
            step_q    <= '0;
          end
        end
        ST_MULT: begin
          if (mplier_q[0]) product_q <= product_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          step_q   <= step_q + MC_W'(1);
        end
        ST_DONE: begin
          w_q     <= prod_ext[RES_W-1:0];
          valid_q <= fits;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (saddress)
      ADDR_W:    rd_data[RES_W-1:0] = w_q;
      ADDR_L:    rd_data[POP_W-1:0] = l_val;
      ADDR_CTRL: begin
        rd_data[STAT_READY_BIT] = ready;
        rd_data[STAT_VALID_BIT] = valid_q;
      end
      default: ;
    endcase
  end

  // Read data is taken from registers before this edge's updates, so a
  // simultaneous write to the same address returns the old value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sdata_out <= '0;
      gpio_in_s <= '0;
    end else begin
      if (srd)        sdata_out <= rd_data;
      if (gpio_latch) gpio_in_s <= gpio_in;
    end
  end

  always_comb begin
    gpio_out = '0;
    gpio_out[CNT_W-1:0] = cnt_q;
  end

  assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpio_mulcnt.sv
// Self-checking bench for gpio_mulcnt against an arithmetic reference model.
module tb_gpio_mulcnt;

  localparam int OP_W  = 24;
  localparam int RES_W = 32;
  localparam int CNT_W = 3;
`ifdef MULCNT_POPCNT_EN
  localparam int LAT    = OP_W + 2;
  localparam bit POP_EN = 1'b1;
`else
  localparam int LAT    = OP_W + 1;
  localparam bit POP_EN = 1'b0;
`endif

  localparam logic [15:0] A_A1   = 16'h037F;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam longint unsigned OPMASK = (64'd1 << OP_W) - 1;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state
  longint unsigned m_a1 = 0, m_a2 = 0;
  int unsigned     m_cnt = 0;
  logic [31:0]     m_w = '0, m_l = '0;
  logic            m_valid = 1'b0;

  gpio_mulcnt #(.OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    saddress = addr; sdata_in = data; swr = 1'b1;
    @(posedge clk); #1;
    swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] data);
    saddress = addr; srd = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    data = sdata_out;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    wr(A_A1, a); m_a1 = longint'(a) & OPMASK;
    wr(A_A2, b); m_a2 = longint'(b) & OPMASK;
  endtask

  // Result of one completed operation, from plain arithmetic.
  task automatic model_op();
    longint unsigned p;
    p = m_a1 * m_a2;
    m_w     = 32'(p);
    m_valid = (p < (64'd1 << RES_W));
    m_l     = POP_EN ? 32'($countones(32'(p))) : 32'd0;
    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic run_op(input bit busy_pokes, input bit use_rdwr);
    logic [31:0] r, nw1, nw2, old_w;
    logic        old_v;
    int          used;
    old_w = m_w; old_v = m_valid;
    if (use_rdwr) begin
      saddress = A_CTRL; sdata_in = $urandom; srd = 1'b1; swr = 1'b1;
      @(posedge clk); #1;
      srd = 1'b0; swr = 1'b0;
      check("rdwr_prewrite_status", sdata_out, {30'b0, 1'b1, old_v});
    end else begin
      wr(A_CTRL, $urandom);
    end
    rd(A_W, r);
    check("w_during_op", r, old_w);
    used = 1;
    nw1 = '0; nw2 = '0;
    if (busy_pokes) begin
      nw1 = $urandom; nw2 = $urandom;
      wr(A_A1, nw1); wr(A_A2, nw2); wr(A_CTRL, 32'h0);
      used = 4;
    end
    repeat (LAT - 1 - used) @(posedge clk);
    #1;
    rd(A_CTRL, r);
    check("status_before_done", r, {30'b0, 1'b0, old_v});
    model_op();
    if (busy_pokes) begin
      m_a1 = longint'(nw1) & OPMASK;
      m_a2 = longint'(nw2) & OPMASK;
    end
    rd(A_CTRL, r); check("status_done", r, {30'b0, 1'b1, m_valid});
    rd(A_W, r);    check("w_result", r, m_w);
    rd(A_L, r);    check("l_result", r, m_l);
    check("gpio_out_cnt", gpio_out, 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] r, a, b, g;
    logic [15:0] ua;

    // Reset state
    #1 n_reset = 1'b0;
    #2;
    check("reset_sdata_out", sdata_out, 32'h0);
    check("reset_gpio_out", gpio_out, 32'h0);
    check("reset_insp", gpio_in_s_insp, 32'h0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    rd(A_CTRL, r); check("reset_status", r, 32'h2);
    rd(A_W, r);    check("reset_w", r, 32'h0);

    // 3 x 5
    set_ops(32'd3, 32'd5);
    run_op(1'b0, 1'b0);

    // Largest operands: product overflows RES_W
    set_ops(32'h00FF_FFFF, 32'h00FF_FFFF);
    run_op(1'b0, 1'b0);

    // Restart and operand writes while busy are ignored by the running operation
    set_ops(32'd1234, 32'd77);
    run_op(1'b1, 1'b0);

    // Simultaneous read/write on the control register
    set_ops(32'd3, 32'd5);
    run_op(1'b0, 1'b1);

    // Unmapped reads
    rd(16'h0400, r); check("unmapped_0400", r, 32'h0);
    for (int i = 0; i < 3; i++) begin
      ua = 16'($urandom);
      if (ua == A_A1 || ua == A_A2 || ua == A_W || ua == A_L || ua == A_CTRL) ua = 16'h0401;
      rd(ua, r); check("unmapped_rand", r, 32'h0);
    end

    // Input capture
    gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
    @(posedge clk); #1;
    gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
    check("latch_capture", gpio_in_s_insp, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    check("latch_hold", gpio_in_s_insp, 32'hA5A5_A5A5);

    // Randomised operations, some with busy pokes; counter wraps
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      if (i % 4 == 1) a = a & 32'h0000_00FF;
      set_ops(a, b);
      run_op(i % 3 == 0, i % 4 == 2);
    end

    // Abort an operation with reset
    set_ops(32'h00AB_CDEF, 32'h0012_3456);
    rd(A_W, r);
    g = $urandom | 32'h1;
    gpio_in = g; gpio_latch = 1'b1;
    wr(A_CTRL, 32'h1);
    gpio_latch = 1'b0;
    repeat (10) @(posedge clk);
    #1 n_reset = 1'b0;
    #2;
    check("abort_sdata_out", sdata_out, 32'h0);
    check("abort_gpio_out", gpio_out, 32'h0);
    check("abort_insp", gpio_in_s_insp, 32'h0);
    m_a1 = 0; m_a2 = 0; m_cnt = 0; m_w = '0; m_l = '0; m_valid = 1'b0;
    @(posedge clk);
    #1 n_reset = 1'b1;
    rd(A_CTRL, r); check("abort_status", r, 32'h2);
    rd(A_W, r);    check("abort_w", r, 32'h0);
    rd(A_L, r);    check("abort_l", r, 32'h0);
    set_ops(32'd3, 32'd5);
    run_op(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
